// File: rtl/hash_op_scheduler.sv
// hash_op_scheduler: round-robin front end for the cuckoo hash table controller.
// Grants one requester at a time and walks the operation through the hash,
// table read and commit phases, then holds a tagged response until it is accepted.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for an eligible requester, grant issued here
// HASH   | waiting HASH_LATENCY cycles for hash addresses to settle
// LOOKUP | one-cycle table read strobe
// COMMIT | op code driven to the controller, status/data captured
// RESP   | response presented until resp_ready_i
module hash_op_scheduler #(
    parameter int KEY_WIDTH    = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REQ      = 4,
    parameter int HASH_LATENCY = 1,
    parameter int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [2*NUM_REQ-1:0]          req_op_i,
    input  logic [KEY_WIDTH*NUM_REQ-1:0]  req_key_i,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [KEY_WIDTH-1:0]          key_o,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic [1:0]                    delete_write_read_o,
    output logic                          table_rd_en_o,
    input  logic [DATA_WIDTH-1:0]         ctl_read_data_i,
    input  logic                          ctl_no_element_i,
    input  logic                          ctl_no_write_space_i,
    input  logic                          ctl_key_present_i,
    input  logic                          ctl_no_del_target_i,
    output logic                          resp_valid_o,
    input  logic                          resp_ready_i,
    output logic [ID_W-1:0]               resp_id_o,
    output logic [2:0]                    resp_status_o,
    output logic [DATA_WIDTH-1:0]         resp_data_o,
    output logic                          busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HASH,
        S_LOOKUP,
        S_COMMIT,
        S_RESP
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_DEL   = 2'b11;

    localparam logic [2:0] ST_OK            = 3'd0;
    localparam logic [2:0] ST_NOT_FOUND     = 3'd1;
    localparam logic [2:0] ST_NO_SPACE      = 3'd2;
    localparam logic [2:0] ST_KEY_PRESENT   = 3'd3;
    localparam logic [2:0] ST_NO_DEL_TARGET = 3'd4;

    localparam logic [3:0] HASH_LOAD = 4'((HASH_LATENCY > 0) ? HASH_LATENCY - 1 : 0);

    state_t                state, state_nxt;
    logic [ID_W-1:0]       last_grant;
    logic [ID_W-1:0]       cur_id;
    logic [1:0]            cur_op;
    logic [3:0]            hash_cnt;

    logic                  hi_found, lo_found;
    logic [ID_W-1:0]       hi_idx, lo_idx, pick;
    logic                  grant;
    logic [1:0]            sel_op;
    logic [KEY_WIDTH-1:0]  sel_key;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [2:0]            status_nxt;
    logic [DATA_WIDTH-1:0] data_nxt;

    // Cyclic search: lowest eligible index above last_grant, else lowest overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[k] && (req_op_i[2*k +: 2] != 2'b00)) begin
                if (ID_W'(k) > last_grant) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(k);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = ID_W'(k);
                end
            end
        end
        pick  = hi_found ? hi_idx : lo_idx;
        grant = (state == S_IDLE) && (hi_found || lo_found) && !rst;
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_op   = '0;
        sel_key  = '0;
        sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick == ID_W'(k)) begin
                sel_op   = req_op_i[2*k +: 2];
                sel_key  = req_key_i[k*KEY_WIDTH +: KEY_WIDTH];
                sel_data = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // State register and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else begin
            state <= state_nxt;
            if (grant) last_grant <= pick;
        end
    end

    // Next-state logic and phase strobes; strobes decode the state directly so
    // an asynchronous reset removes them without waiting for a clock.
    always_comb begin
        state_nxt           = state;
        req_ready_o         = '0;
        table_rd_en_o       = 1'b0;
        delete_write_read_o = 2'b00;
        resp_valid_o        = 1'b0;
        busy_o              = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (grant) begin
                    req_ready_o = NUM_REQ'(1) << pick;
                    state_nxt   = (HASH_LATENCY > 0) ? S_HASH : S_LOOKUP;
                end
            end
            S_HASH: begin
                if (hash_cnt == 4'd0) state_nxt = S_LOOKUP;
            end
            S_LOOKUP: begin
                table_rd_en_o = 1'b1;
                state_nxt     = S_COMMIT;
            end
            S_COMMIT: begin
                delete_write_read_o = cur_op;
                state_nxt           = S_RESP;
            end
            S_RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status priority per op; read data is only returned on a read hit.
    always_comb begin
        status_nxt = ST_OK;
        case (cur_op)
            OP_WRITE: begin
                if (ctl_key_present_i)         status_nxt = ST_KEY_PRESENT;
                else if (ctl_no_write_space_i) status_nxt = ST_NO_SPACE;
            end
            OP_READ:  if (ctl_no_element_i)    status_nxt = ST_NOT_FOUND;
            OP_DEL:   if (ctl_no_del_target_i) status_nxt = ST_NO_DEL_TARGET;
            default: ;
        endcase
        data_nxt = ((cur_op == OP_READ) && !ctl_no_element_i) ? ctl_read_data_i : '0;
    end

    // Operand latch at grant, hash wait counter, and response capture in COMMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_id        <= '0;
            cur_op        <= '0;
            key_o         <= '0;
            data_o        <= '0;
            hash_cnt      <= '0;
            resp_id_o     <= '0;
            resp_status_o <= '0;
            resp_data_o   <= '0;
        end else begin
            if (grant) begin
                cur_id   <= pick;
                cur_op   <= sel_op;
                key_o    <= sel_key;
                data_o   <= sel_data;
                hash_cnt <= HASH_LOAD;
            end else if ((state == S_HASH) && (hash_cnt != 4'd0)) begin
                hash_cnt <= hash_cnt - 4'd1;
            end
            if (state == S_COMMIT) begin
                resp_id_o     <= cur_id;
                resp_status_o <= status_nxt;
                resp_data_o   <= data_nxt;
            end
        end
    end

endmodule

// File: tb/tb_hash_op_scheduler.sv
// Testbench for hash_op_scheduler: directed stimulus, expected responses queued
// at issue time and consumed by independent monitors for each instance.
module tb_hash_op_scheduler;
    localparam int KW = 2;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int IW = 2;

    typedef struct {
        logic [IW-1:0] id;
        logic [2:0]    st;
        logic [DW-1:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_valid_z = '0;
    logic [2*NR-1:0]  req_op = '0;
    logic [KW*NR-1:0] req_key = '0;
    logic [DW*NR-1:0] req_data = '0;
    logic [DW-1:0]    ctl_rd = '0;
    logic no_el = 1'b0, no_ws = 1'b0, kp = 1'b0, no_dt = 1'b0;
    logic resp_ready = 1'b1;

    logic [NR-1:0] ready_a, ready_z;
    logic [KW-1:0] key_a, key_z;
    logic [DW-1:0] data_a, data_z, rdata_a, rdata_z;
    logic [1:0]    dwr_a, dwr_z;
    logic          rd_en_a, rd_en_z, rv_a, rv_z, busy_a, busy_z;
    logic [IW-1:0] rid_a, rid_z;
    logic [2:0]    st_a, st_z;

    hash_op_scheduler #(.KEY_WIDTH(KW), .DATA_WIDTH(DW), .NUM_REQ(NR), .HASH_LATENCY(1)) u_a (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_op_i(req_op), .req_key_i(req_key), .req_data_i(req_data),
        .req_ready_o(ready_a), .key_o(key_a), .data_o(data_a),
        .delete_write_read_o(dwr_a), .table_rd_en_o(rd_en_a),
        .ctl_read_data_i(ctl_rd), .ctl_no_element_i(no_el), .ctl_no_write_space_i(no_ws),
        .ctl_key_present_i(kp), .ctl_no_del_target_i(no_dt),
        .resp_valid_o(rv_a), .resp_ready_i(resp_ready), .resp_id_o(rid_a),
        .resp_status_o(st_a), .resp_data_o(rdata_a), .busy_o(busy_a));

    hash_op_scheduler #(.KEY_WIDTH(KW), .DATA_WIDTH(DW), .NUM_REQ(NR), .HASH_LATENCY(0)) u_z (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_z), .req_op_i(req_op), .req_key_i(req_key), .req_data_i(req_data),
        .req_ready_o(ready_z), .key_o(key_z), .data_o(data_z),
        .delete_write_read_o(dwr_z), .table_rd_en_o(rd_en_z),
        .ctl_read_data_i(ctl_rd), .ctl_no_element_i(no_el), .ctl_no_write_space_i(no_ws),
        .ctl_key_present_i(kp), .ctl_no_del_target_i(no_dt),
        .resp_valid_o(rv_z), .resp_ready_i(resp_ready), .resp_id_o(rid_z),
        .resp_status_o(st_z), .resp_data_o(rdata_z), .busy_o(busy_z));

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t q_a[$];
    exp_t q_z[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit z, input int k, input logic [2:0] st, input logic [DW-1:0] d);
        exp_t e;
        e.id = IW'(k);
        e.st = st;
        e.d  = d;
        if (z) q_z.push_back(e);
        else   q_a.push_back(e);
    endtask

    // Response monitors: pop the expected entry on every accepted response.
    initial forever begin
        exp_t e;
        @(negedge clk); #2;
        if (!rst && rv_a && resp_ready) begin
            if (q_a.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL a_unexpected_resp: got id %0d status %0d, expected no response", rid_a, st_a);
            end else begin
                e = q_a.pop_front();
                check("a_resp_id", 64'(rid_a), 64'(e.id));
                check("a_resp_status", 64'(st_a), 64'(e.st));
                check("a_resp_data", 64'(rdata_a), 64'(e.d));
            end
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk); #2;
        if (!rst && rv_z && resp_ready) begin
            if (q_z.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL z_unexpected_resp: got id %0d status %0d, expected no response", rid_z, st_z);
            end else begin
                e = q_z.pop_front();
                check("z_resp_id", 64'(rid_z), 64'(e.id));
                check("z_resp_status", 64'(st_z), 64'(e.st));
                check("z_resp_data", 64'(rdata_z), 64'(e.d));
            end
        end
    end

    task automatic set_req(input int k, input logic [1:0] op, input logic [KW-1:0] key,
                           input logic [DW-1:0] d);
        req_op[2*k +: 2]     = op;
        req_key[k*KW +: KW]  = key;
        req_data[k*DW +: DW] = d;
    endtask

    // Called at negedge+1; returns the first non-zero grant vector.
    task automatic wait_grant(input bit z, output logic [NR-1:0] g, output int t);
        g = '0;
        t = cyc;
        for (int i = 0; i < 40; i++) begin
            g = z ? ready_z : ready_a;
            if (g != '0) begin
                t = cyc;
                return;
            end
            @(negedge clk); #1;
        end
        n_checks++; n_errors++;
        $display("FAIL grant_timeout: got no grant, expected one within 40 cycles");
    endtask

    task automatic wait_resp_a();
        for (int i = 0; i < 40; i++) begin
            if (rv_a) return;
            @(negedge clk); #1;
        end
        n_checks++; n_errors++;
        $display("FAIL resp_timeout: got no resp_valid, expected one within 40 cycles");
    endtask

    task automatic wait_idle_a();
        for (int i = 0; i < 40; i++) begin
            if (!busy_a) return;
            @(negedge clk); #1;
        end
        n_checks++; n_errors++;
        $display("FAIL idle_timeout: got busy, expected idle within 40 cycles");
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic run_op(input int k, input logic [1:0] op, input logic [KW-1:0] key,
                          input logic [DW-1:0] d, input logic [2:0] st, input logic [DW-1:0] ed);
        logic [NR-1:0] g;
        int t;
        @(negedge clk);
        set_req(k, op, key, d);
        req_valid[k] = 1'b1;
        push(1'b0, k, st, ed);
        #1;
        wait_grant(1'b0, g, t);
        check("op_grant", 64'(g), 64'(1) << k);
        @(negedge clk);
        req_valid[k] = 1'b0;
        #1;
        wait_resp_a();
        @(negedge clk); #1;
        wait_idle_a();
    endtask

    initial begin
        logic [NR-1:0] g;
        int t, tprev;
        tprev = 0;

        // Reset values, with requests present during reset.
        req_valid = 4'b1111;
        req_op    = 8'b01010101;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", 64'(ready_a), 0);
        check("rst_busy", 64'(busy_a), 0);
        check("rst_key", 64'(key_a), 0);
        check("rst_data", 64'(data_a), 0);
        check("rst_dwr", 64'(dwr_a), 0);
        check("rst_rd_en", 64'(rd_en_a), 0);
        check("rst_resp_valid", 64'(rv_a), 0);
        check("rst_resp_id", 64'(rid_a), 0);
        check("rst_resp_status", 64'(st_a), 0);
        check("rst_resp_data", 64'(rdata_a), 0);
        @(negedge clk);
        req_valid = '0;
        req_op    = '0;
        rst       = 1'b0;

        // Reset in the middle of LOOKUP drops the transaction.
        @(negedge clk);
        set_req(0, 2'b01, 2'd3, 32'hA5A5_0001);
        req_valid[0] = 1'b1;
        #1;
        check("midrst_grant", 64'(ready_a), 64'b0001);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk); #1;
        check("midrst_lookup", 64'(rd_en_a), 1);
        check("midrst_key", 64'(key_a), 3);
        rst = 1'b1;
        #1;
        check("midrst_rd_en", 64'(rd_en_a), 0);
        check("midrst_busy", 64'(busy_a), 0);
        check("midrst_key_clr", 64'(key_a), 0);
        check("midrst_data_clr", 64'(data_a), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            check("midrst_no_resp", 64'(rv_a), 0);
        end

        // Single write from requester 2, cycle-accurate phase checks.
        @(negedge clk);
        set_req(2, 2'b10, 2'd1, 32'hDEAD_BEEF);
        req_valid[2] = 1'b1;
        push(1'b0, 2, 3'd0, 32'h0);
        #1;
        check("wr_c0_ready", 64'(ready_a), 64'b0100);
        @(negedge clk);
        req_valid[2] = 1'b0;
        #1;
        check("wr_c1_rd_en", 64'(rd_en_a), 0);
        check("wr_c1_dwr", 64'(dwr_a), 0);
        check("wr_c1_busy", 64'(busy_a), 1);
        @(negedge clk); #1;
        check("wr_c2_rd_en", 64'(rd_en_a), 1);
        check("wr_c2_dwr", 64'(dwr_a), 0);
        @(negedge clk); #1;
        check("wr_c3_dwr", 64'(dwr_a), 64'b10);
        check("wr_c3_rd_en", 64'(rd_en_a), 0);
        check("wr_c3_valid", 64'(rv_a), 0);
        @(negedge clk); #1;
        check("wr_c4_valid", 64'(rv_a), 1);
        check("wr_c4_dwr", 64'(dwr_a), 0);
        check("wr_c4_key", 64'(key_a), 1);
        check("wr_c4_data", 64'(data_a), 64'hDEAD_BEEF);
        @(negedge clk); #1;
        check("wr_c5_valid", 64'(rv_a), 0);
        check("wr_c5_busy", 64'(busy_a), 0);
        check("wr_hold_key", 64'(key_a), 1);

        // Round robin from reset priority: 0,1,2,3,0, one grant per 5 cycles.
        pulse_reset();
        ctl_rd = 32'h0000_1234;
        @(negedge clk);
        for (int k = 0; k < NR; k++) set_req(k, 2'b01, KW'(k), 32'h0);
        req_valid = 4'b1111;
        push(1'b0, 0, 3'd0, 32'h1234);
        push(1'b0, 1, 3'd0, 32'h1234);
        push(1'b0, 2, 3'd0, 32'h1234);
        push(1'b0, 3, 3'd0, 32'h1234);
        push(1'b0, 0, 3'd0, 32'h1234);
        #1;
        for (int n = 0; n < 5; n++) begin
            wait_grant(1'b0, g, t);
            check("rr_grant", 64'(g), 64'(1) << (n % 4));
            if (n > 0) check("rr_interval", 64'(t - tprev), 5);
            tprev = t;
            @(negedge clk);
            if (n == 4) req_valid = '0;
            #1;
        end
        wait_idle_a();

        // Status mapping.
        no_el = 1'b1; ctl_rd = 32'hFFFF_FFFF;
        run_op(1, 2'b01, 2'd2, 32'h0, 3'd1, 32'h0);
        no_el = 1'b0;
        kp = 1'b1; no_ws = 1'b1;
        run_op(2, 2'b10, 2'd3, 32'h0BAD_F00D, 3'd3, 32'h0);
        kp = 1'b0;
        run_op(3, 2'b10, 2'd0, 32'h1111_2222, 3'd2, 32'h0);
        no_ws = 1'b0;
        no_dt = 1'b1;
        run_op(0, 2'b11, 2'd1, 32'h0, 3'd4, 32'h0);
        no_dt = 1'b0;
        ctl_rd = 32'h0000_1234;
        run_op(1, 2'b01, 2'd1, 32'h0, 3'd0, 32'h1234);

        // Backpressure: response held, pending requester 1 not granted.
        pulse_reset();
        ctl_rd     = 32'h0000_CAFE;
        resp_ready = 1'b0;
        @(negedge clk);
        set_req(0, 2'b01, 2'd2, 32'h0);
        req_valid[0] = 1'b1;
        push(1'b0, 0, 3'd0, 32'hCAFE);
        #1;
        wait_grant(1'b0, g, t);
        check("bp_first_grant", 64'(g), 64'b0001);
        @(negedge clk);
        req_valid[0] = 1'b0;
        set_req(1, 2'b10, 2'd3, 32'h5555_AAAA);
        req_valid[1] = 1'b1;
        push(1'b0, 1, 3'd0, 32'h0);
        #1;
        wait_resp_a();
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 64'(rv_a), 1);
            check("bp_id", 64'(rid_a), 0);
            check("bp_status", 64'(st_a), 0);
            check("bp_data", 64'(rdata_a), 64'hCAFE);
            check("bp_busy", 64'(busy_a), 1);
            check("bp_no_grant", 64'(ready_a), 0);
            @(negedge clk); #1;
        end
        check("bp_handshake_cycle_ready", 64'(ready_a), 0);
        resp_ready = 1'b1;
        @(negedge clk); #1;
        check("bp_grant_after_handshake", 64'(ready_a), 64'b0010);
        @(negedge clk);
        req_valid[1] = 1'b0;
        #1;
        wait_resp_a();
        @(negedge clk); #1;
        wait_idle_a();

        // HASH_LATENCY=0 instance: op 00 ignored, delete from requester 3.
        @(negedge clk);
        set_req(0, 2'b00, 2'd0, 32'h0);
        set_req(3, 2'b11, 2'd1, 32'h0);
        req_valid_z = 4'b1001;
        push(1'b1, 3, 3'd0, 32'h0);
        #1;
        check("z_c0_ready", 64'(ready_z), 64'b1000);
        @(negedge clk);
        req_valid_z[3] = 1'b0;
        #1;
        check("z_c1_rd_en", 64'(rd_en_z), 1);
        check("z_c1_dwr", 64'(dwr_z), 0);
        @(negedge clk); #1;
        check("z_c2_dwr", 64'(dwr_z), 64'b11);
        check("z_c2_rd_en", 64'(rd_en_z), 0);
        @(negedge clk); #1;
        check("z_c3_valid", 64'(rv_z), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check("z_op00_no_grant", 64'(ready_z), 0);
            check("z_op00_idle", 64'(busy_z), 0);
        end
        req_valid_z = '0;

        repeat (3) @(negedge clk);
        check("a_queue_drained", 64'(q_a.size()), 0);
        check("z_queue_drained", 64'(q_z.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
